// File: rtl/hdmi_audio_pkg.sv
// Shared types and constants for the HDMI audio packet path.
package hdmi_audio_pkg;

    typedef enum logic [1:0] {PRIME, STREAM, HOLD} sched_state_t;

    localparam int MAX_SAMPLES       = 4;
    localparam int IEC_BLOCK_DEFAULT = 192;

    // Subpacket occupancy: the low n lanes are filled.
    function automatic logic [MAX_SAMPLES-1:0] lane_mask(input logic [2:0] n);
        logic [MAX_SAMPLES-1:0] m;
        for (int i = 0; i < MAX_SAMPLES; i++) m[i] = (i < int'(n));
        return m;
    endfunction

endpackage

// File: rtl/audio_packet_scheduler_if.sv
// Packet-picker side of the audio scheduler: request/grant plus the packet descriptor.
interface audio_packet_scheduler_if;
    import hdmi_audio_pkg::*;

    logic                   packet_req;
    logic                   packet_grant;
    logic                   packet_valid;
    logic [MAX_SAMPLES-1:0] sample_present;
    logic [MAX_SAMPLES-1:0] block_start;
    logic [7:0]             frame_index;

    modport master (
        output packet_req, packet_valid, sample_present, block_start, frame_index,
        input  packet_grant
    );

    modport slave (
        input  packet_req, packet_valid, sample_present, block_start, frame_index,
        output packet_grant
    );

endinterface

// File: rtl/iec_frame_counter.sv
// Mod-IEC_BLOCK frame counter; flags the lanes of a packet that open a new IEC block.
module iec_frame_counter
    import hdmi_audio_pkg::*;
#(
    parameter int IEC_BLOCK = IEC_BLOCK_DEFAULT
) (
    input  logic                   clk_pixel,
    input  logic                   reset,
    input  logic                   advance,
    input  logic [2:0]             count,
    output logic [7:0]             frame_index,
    output logic [MAX_SAMPLES-1:0] block_start
);

    localparam logic [8:0] BLK = 9'(IEC_BLOCK);

    logic [8:0]             sum_next;
    logic [7:0]             idx_next;
    logic [MAX_SAMPLES-1:0] bs_next;

    // frame_index < IEC_BLOCK and count <= 4, so one subtract covers every wrap
    always_comb begin
        sum_next = {1'b0, frame_index} + {6'd0, count};
        idx_next = (sum_next >= BLK) ? 8'(sum_next - BLK) : sum_next[7:0];
    end

    for (genvar i = 0; i < MAX_SAMPLES; i++) begin : g_lane
        logic [8:0] lane_sum;
        assign lane_sum   = {1'b0, frame_index} + 9'(i);
        assign bs_next[i] = (3'(i) < count) && (lane_sum == BLK || lane_sum == 9'd0);
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            frame_index <= '0;
            block_start <= '0;
        end else if (advance) begin
            frame_index <= idx_next;
            block_start <= bs_next;
        end
    end

endmodule

// File: rtl/audio_packet_scheduler.sv
// Paces audio sample packets: primes the buffer, requests a slot, then holds
// for one packet time before the next request.
module audio_packet_scheduler
    import hdmi_audio_pkg::*;
#(
    parameter int BUFFER_SIZE   = 128,
    parameter int START_LEVEL   = 4,
    parameter int PACKET_CYCLES = 32,
    parameter int IEC_BLOCK     = IEC_BLOCK_DEFAULT
) (
    input  logic                           clk_pixel,
    input  logic                           reset,
    input  logic                           audio_enable,
    input  logic [$clog2(BUFFER_SIZE)-1:0] remaining,
    audio_packet_scheduler_if.master       pkt,
    output logic                           packet_enable,
    output logic [15:0]                    underrun_count,
    output logic                           near_full
);

    localparam int RW = $clog2(BUFFER_SIZE);
    localparam int CW = $clog2(PACKET_CYCLES + 1);
    localparam logic [RW-1:0] START_LV  = RW'(START_LEVEL);
    localparam logic [RW-1:0] FULL_LV   = RW'(BUFFER_SIZE - 2);
    localparam logic [RW-1:0] MAX_LV    = RW'(MAX_SAMPLES);
    localparam logic [CW-1:0] HOLD_LAST = CW'(PACKET_CYCLES - 1);

    sched_state_t  state, state_nxt;
    logic [CW-1:0] hold_cnt;
    logic [2:0]    n_samples;
    logic          have_data, hold_done, underrun;

    always_comb begin
        have_data      = (remaining != '0);
        n_samples      = (remaining >= MAX_LV) ? 3'(MAX_SAMPLES) : 3'(remaining);
        hold_done      = (state == HOLD) && (hold_cnt == HOLD_LAST);
        underrun       = hold_done && audio_enable && !have_data;
        pkt.packet_req = 1'b0;
        packet_enable  = 1'b0;
        state_nxt      = state;
        case (state)
            PRIME:  if (audio_enable && remaining >= START_LV) state_nxt = STREAM;
            STREAM: begin
                pkt.packet_req = audio_enable && have_data;
                packet_enable  = pkt.packet_req && pkt.packet_grant;
                if (!audio_enable)     state_nxt = PRIME;
                else if (packet_enable) state_nxt = HOLD;
            end
            HOLD:   if (hold_done) state_nxt = (audio_enable && have_data) ? STREAM : PRIME;
            default: state_nxt = PRIME;
        endcase
        if (reset) begin
            pkt.packet_req = 1'b0;
            packet_enable  = 1'b0;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state              <= PRIME;
            hold_cnt           <= '0;
            pkt.packet_valid   <= 1'b0;
            pkt.sample_present <= '0;
            underrun_count     <= '0;
            near_full          <= 1'b0;
        end else begin
            state            <= state_nxt;
            hold_cnt         <= (state == HOLD && !hold_done) ? hold_cnt + 1'b1 : '0;
            pkt.packet_valid <= packet_enable;
            if (packet_enable) pkt.sample_present <= lane_mask(n_samples);
            if (underrun && underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
            if (remaining >= FULL_LV) near_full <= 1'b1;
        end
    end

    iec_frame_counter #(.IEC_BLOCK(IEC_BLOCK)) u_frame (
        .clk_pixel   (clk_pixel),
        .reset       (reset),
        .advance     (packet_enable),
        .count       (n_samples),
        .frame_index (pkt.frame_index),
        .block_start (pkt.block_start)
    );

endmodule

// File: doc/audio_packet_scheduler.md
AUDIO_PACKET_SCHEDULER -- requirements
Module: audio_packet_scheduler

Interface
REQ-001 SHALL have parameter BUFFER_SIZE, default 128, the depth of the attached audio sample buffer.
REQ-002 SHALL have parameter START_LEVEL, default 4, the minimum fill level required before streaming begins.
REQ-003 SHALL have parameter PACKET_CYCLES, default 32, the pixel clocks one audio sample packet occupies.
REQ-004 SHALL have parameter IEC_BLOCK, default 192, the number of IEC 60958 frames per block.
REQ-005 SHALL have a single clock and a synchronous, active-high reset; there are no other clocks.
REQ-006 SHALL have these ports:
- clk_pixel  in  1  pixel clock; sole clock.
- reset  in  1  synchronous, active-high.
- audio_enable  in  1  permits streaming.
- remaining  in  $clog2(BUFFER_SIZE)  buffer fill level; non-decreasing except on removal.
- packet_grant  in  1  one-cycle slot grant from the packet picker.
- packet_req  out  1  audio packet pending.
- packet_enable  out  1  buffer removal strobe.
- packet_valid  out  1  descriptor valid, one-cycle pulse.
- sample_present  out  4  subpacket occupancy.
- block_start  out  4  IEC B flag per subpacket.
- frame_index  out  8  next IEC frame number, 0..IEC_BLOCK-1.
- underrun_count  out  16  saturating underrun count.
- near_full  out  1  sticky overflow warning.

Function
REQ-007 SHALL implement the states PRIME, STREAM and HOLD.
REQ-008 PRIME SHALL transition to STREAM when audio_enable=1 and remaining>=START_LEVEL, and SHALL otherwise remain in PRIME.
REQ-009 In STREAM, packet_req SHALL be driven combinationally as audio_enable && remaining>0.
REQ-010 In STREAM, if audio_enable=0, the block SHALL transition to PRIME.
REQ-011 packet_enable SHALL be combinational, equal to (state==STREAM && packet_grant && remaining>0 && audio_enable), so that the buffer removes in the grant cycle.
REQ-012 For each packet, the sample count SHALL be n = min(remaining, 4), sampled in the grant cycle.
REQ-013 packet_enable=1 SHALL cause a transition to HOLD.
REQ-014 On the edge ending the grant cycle, packet_valid SHALL be registered to 1 for exactly one cycle, giving a descriptor latency of 1 cycle.
REQ-015 On that same edge, sample_present SHALL be registered to (1<<n)-1.
REQ-016 On that same edge, block_start[i] SHALL be set to 1 iff i<n and (frame_index+i) mod IEC_BLOCK == 0.
REQ-017 On that same edge, frame_index SHALL advance to (frame_index+n) mod IEC_BLOCK, wrapping correctly across 191->0 for any n.
REQ-018 A packet_grant in any state other than STREAM, or while remaining=0, SHALL be ignored, with no packet_enable and no state change.
REQ-019 HOLD SHALL last exactly PACKET_CYCLES cycles, with packet_grant ignored throughout.
REQ-020 When HOLD ends, if audio_enable=1 and remaining>0, the next state SHALL be STREAM.
REQ-021 When HOLD ends with audio_enable=1 and remaining=0 (underrun), the next state SHALL be PRIME and underrun_count SHALL increment, saturating at 16'hFFFF.
REQ-022 When HOLD ends with audio_enable=0, the next state SHALL be PRIME with no increment; deasserting audio_enable mid-HOLD SHALL NOT shorten the hold.
REQ-023 frame_index SHALL be preserved across PRIME and SHALL be cleared only by reset.
REQ-024 near_full SHALL set when remaining >= BUFFER_SIZE-2 in any state and SHALL clear only on reset.
REQ-025 sample_present and block_start SHALL hold their last values between packet_valid pulses.

Reset
REQ-026 Reset SHALL take priority over all other inputs in the same cycle.
REQ-027 On reset: state=PRIME, HOLD counter=0, packet_valid=0, sample_present=0, block_start=0, frame_index=0, underrun_count=0, near_full=0.
REQ-028 packet_req and packet_enable SHALL be 0 during reset.
REQ-029 Reset asserted during HOLD SHALL abort the hold, with no underrun counted.

Structure
REQ-030 The state enum, MAX_SAMPLES=4 and IEC_BLOCK_DEFAULT=192 SHALL live in the shared package hdmi_audio_pkg.
REQ-031 The mod-IEC_BLOCK frame counter and block_start generation SHALL be one sub-module, iec_frame_counter.
REQ-032 No multiply or divide SHALL appear in the RTL; the wrap SHALL be a compare-subtract.

Verification
REQ-033 Priming: remaining=3, enable=1 -> PRIME, packet_req=0; remaining=4 -> STREAM next cycle, packet_req=1.
REQ-034 Partial packet: remaining=2, grant -> packet_enable=1 that cycle; next cycle packet_valid=1, sample_present=4'b0011; HOLD for exactly 32 cycles.
REQ-035 Block wrap: frame_index=190, remaining=10, grant -> sample_present=4'b1111, block_start=4'b0100, frame_index=2.
REQ-036 Underrun: remaining drops to 0 during HOLD -> PRIME after 32 cycles, underrun_count=1; at 16'hFFFF a further underrun leaves it at 16'hFFFF.
REQ-037 Ignored grants: a grant during HOLD or PRIME -> packet_enable=0 and packet_valid=0; near_full=1 after remaining=126 and persists until reset.
REQ-038 Reset mid-HOLD at cycle 10 -> next cycle state=PRIME, all outputs at their reset values, underrun_count=0.
